sbox_sub_unit: RTL and testbench
================================

SBOX_SUB_UNIT -- requirements
Module: sbox_sub_unit

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of parallel byte lanes (legal 1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the accepted-transaction counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: input word present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts the input word this cycle.
REQ-007 The block SHALL have port in_data, input, LANES*8 bits: lane i occupies bits [8i+7:8i].
REQ-008 The block SHALL have port in_mask, input, LANES bits: 1 means substitute the lane, 0 means pass it through unchanged.
REQ-009 The block SHALL have port in_inv, input, 1 bit: 1 selects the inverse S-box for the whole word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result word present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, LANES*8 bits: substituted word.
REQ-013 The block SHALL have port acc_cnt, output, CNT_W bits: saturating count of accepted input words.

Function
REQ-014 Substitution SHALL use the FIPS-197 AES forward S-box and, when enabled, the AES inverse S-box, applied independently per lane.
REQ-015 A word SHALL transfer in when in_valid&&in_ready, and out when out_valid&&out_ready.
REQ-016 The datapath SHALL be a two-stage pipeline: S1 registers data, mask and inv; S2 registers the looked-up result; latency is exactly 2 cycles from the accept edge to out_valid when unstalled.
REQ-017 Stage advance SHALL be s2_adv = !s2_valid || out_ready, s1_adv = !s1_valid || s2_adv, and in_ready = s1_adv; bubbles collapse, and full throughput is 1 word/cycle.
REQ-018 in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 While out_valid=1 and out_ready=0, out_data SHALL remain stable and no held word SHALL be lost or duplicated.
REQ-020 Simultaneous accept and emit on a full pipe SHALL keep both stages full, with data correctly shifted.
REQ-021 acc_cnt SHALL increment by 1 per input transfer and hold at 2^CNT_W-1 with no wrap.
REQ-022 Masked-off lanes SHALL output the input byte unchanged, independent of in_inv.

Reset
REQ-023 While rst_n=0 at a clk edge, s1_valid, s2_valid, out_valid and acc_cnt SHALL clear to 0, and in_ready SHALL read 1 after the reset edge.
REQ-024 Data registers need not reset, but out_data SHALL be don't-care whenever out_valid=0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight words, with no output emitted afterward for them.

Configuration
REQ-026 With macro SBOX_SUB_INV_EN defined, in_inv=1 SHALL select the inverse S-box.
REQ-027 Without SBOX_SUB_INV_EN, the inverse table SHALL be absent, in_inv SHALL be ignored, and forward substitution always applies.

Structure
REQ-028 Package sbox_pkg SHALL hold the forward and inverse S-box constant tables, lookup functions sbox_fwd and sbox_inv, and the LANES legal-range constants.
REQ-029 Sub-module sbox_lane (one byte, mask, inv, purely combinational) SHALL be instantiated LANES times between S1 and S2.

Verification
REQ-030 Reset, then LANES=4, in_data=32'h00_01_53_FF, mask=4'hF, inv=0, out_ready=1 -> out_data=32'h63_7C_ED_16 exactly two cycles after accept.
REQ-031 With SBOX_SUB_INV_EN defined, in_data=32'h63_7C_ED_16, inv=1 -> out_data=32'h00_01_53_FF; without the macro, the same stimulus -> 32'hFB_10_55_47.
REQ-032 mask=4'b0101, data=32'h00_00_00_00, inv=0 -> out_data=32'h00_63_00_63.
REQ-033 Stream of 10 words with out_ready toggling 1,0,0,1... -> all 10 words emerge in order with no drop or duplicate, out_data stable while stalled, and acc_cnt=10.
REQ-034 Fill the pipe (2 words), assert rst_n=0 for one cycle -> out_valid=0 and acc_cnt=0 next cycle, and no stale word appears later.
REQ-035 CNT_W=4, 20 accepted words -> acc_cnt=15 and holds.

Source files
------------

// File: rtl/sbox_pkg.sv
// AES S-box constant tables, lookup functions and lane-count limits.
// The inverse table exists only when SBOX_SUB_INV_EN is defined.
package sbox_pkg;

   localparam int unsigned LANES_MIN = 1;
   localparam int unsigned LANES_MAX = 16;

   localparam logic [7:0] FWD_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return FWD_TABLE[b];
   endfunction

`ifdef SBOX_SUB_INV_EN
   localparam logic [7:0] INV_TABLE [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return INV_TABLE[b];
   endfunction
`endif

endpackage

// File: rtl/sbox_lane.sv
// One byte lane: masked forward/inverse S-box substitution, purely combinational.
// Inverse selection exists only when SBOX_SUB_INV_EN is defined.
module sbox_lane
   import sbox_pkg::*;
(
   input  logic [7:0] data,
   input  logic       mask,
   input  logic       inv,
   output logic [7:0] result_c
);

`ifndef SBOX_SUB_INV_EN
   logic unused_inv;
   assign unused_inv = inv;
`endif

   // Masked-off lanes pass through regardless of direction
   always_comb begin
      result_c = data;
      if (mask) begin
`ifdef SBOX_SUB_INV_EN
         result_c = inv ? sbox_inv(data) : sbox_fwd(data);
`else
         result_c = sbox_fwd(data);
`endif
      end
   end

endmodule

// File: rtl/sbox_sub_unit.sv
// Two-stage valid/ready AES S-box substitution pipeline with saturating accept counter.
// Define SBOX_SUB_INV_EN to honour in_inv (inverse S-box); otherwise forward only.
module sbox_sub_unit
   import sbox_pkg::*;
#(
   parameter int unsigned LANES = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*8-1:0]   in_data,
   input  logic [LANES-1:0]     in_mask,
   input  logic                 in_inv,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*8-1:0]   out_data,
   output logic [CNT_W-1:0]     acc_cnt
);

   localparam int unsigned DATA_W = LANES * 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_lanes_range
      $error("sbox_sub_unit: LANES out of legal range");
   end

   logic              s1_valid;
   logic              s2_valid;
   logic [DATA_W-1:0] s1_data;
   logic [LANES-1:0]  s1_mask;
   logic              s1_inv;
   logic [DATA_W-1:0] lane_res;
   logic              s1_adv;
   logic              s2_adv;
   logic              accept;

   // Each stage moves when the one ahead is empty or draining
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign accept    = in_valid && s1_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         acc_cnt  <= '0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
         if (accept && acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + CNT_W'(1);
      end
   end

   // Data registers carry no reset; their contents are qualified by the valids
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_data <= in_data;
         s1_mask <= in_mask;
      end
      if (s2_adv && s1_valid) out_data <= lane_res;
   end

`ifdef SBOX_SUB_INV_EN
   always_ff @(posedge clk) begin
      if (accept) s1_inv <= in_inv;
   end
`else
   logic unused_in_inv;
   assign unused_in_inv = in_inv;
   assign s1_inv        = 1'b0;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sbox_lane u_lane (
         .data     (s1_data[8*i +: 8]),
         .mask     (s1_mask[i]),
         .inv      (s1_inv),
         .result_c (lane_res[8*i +: 8])
      );
   end

endmodule

// File: tb/tb_sbox_sub_unit.sv
// Bench for sbox_sub_unit: S-box derived from GF(2^8) arithmetic, transaction-level pipe model.
// Expectations follow SBOX_SUB_INV_EN when it is defined.
module tb_sbox_sub_unit;

`ifdef SBOX_SUB_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [3:0]  in_mask = '0;
   logic        in_inv = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [15:0] acc_cnt;

   logic        c4_in_valid = 1'b0;
   logic        c4_in_ready;
   logic        c4_out_valid;
   logic [31:0] c4_out_data;
   logic [3:0]  c4_acc_cnt;

   always #5 clk = ~clk;

   sbox_sub_unit #(.LANES(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mask(in_mask), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .acc_cnt(acc_cnt)
   );

   sbox_sub_unit #(.LANES(4), .CNT_W(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(c4_in_valid), .in_ready(c4_in_ready),
      .in_data(32'h1234_5678), .in_mask(4'hF), .in_inv(1'b0),
      .out_valid(c4_out_valid), .out_ready(1'b1), .out_data(c4_out_data), .acc_cnt(c4_acc_cnt)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   typedef struct {
      logic [31:0] data;
      int          acc;
   } item_t;

   item_t       q[$];
   int          cyc = 0;
   int          cnt_model = 0;
   int          n_emit = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box = affine transform of the multiplicative inverse in GF(2^8)
   task automatic build_tables();
      logic [7:0] inv_b;
      for (int v = 0; v < 256; v++) begin
         inv_b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(v), 8'(y)) == 8'h01) inv_b = 8'(y);
         fwd_tab[v] = inv_b ^ rotl(inv_b, 1) ^ rotl(inv_b, 2) ^ rotl(inv_b, 3) ^ rotl(inv_b, 4) ^ 8'h63;
      end
      for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);
   endtask

   function automatic logic [31:0] expect_word(input logic [31:0] d, input logic [3:0] m, input logic inv);
      logic [31:0] r = d;
      logic [7:0]  b;
      for (int i = 0; i < 4; i++) begin
         b = d[8*i +: 8];
         if (m[i]) r[8*i +: 8] = (INV_EN && inv) ? inv_tab[b] : fwd_tab[b];
      end
      return r;
   endfunction

   // One clock: check at negedge against the model, then advance the model at posedge
   task automatic cycle();
      bit exp_rdy, exp_vld, acc, emit;
      @(negedge clk);
      exp_rdy = (q.size() < 2) || out_ready;
      exp_vld = (q.size() > 0) && (cyc - q[0].acc >= 1);
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(exp_vld));
      chk("acc_cnt", 64'(acc_cnt), 64'(cnt_model));
      if (exp_vld) chk("out_data", 64'(out_data), 64'(q[0].data));
      if (prev_stall) chk("stall_hold", 64'(out_data), 64'(prev_data));
      acc        = in_valid && exp_rdy;
      emit       = exp_vld && out_ready;
      prev_stall = exp_vld && !out_ready;
      prev_data  = out_data;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         q.delete();
         cnt_model  = 0;
         prev_stall = 1'b0;
      end else begin
         if (emit) begin
            void'(q.pop_front());
            n_emit++;
         end
         if (acc) begin
            q.push_back('{expect_word(in_data, in_mask, in_inv), cyc});
            if (cnt_model < 65535) cnt_model++;
         end
      end
      #1;
   endtask

   task automatic send_one(input logic [31:0] d, input logic [3:0] m, input logic inv);
      in_valid = 1'b1; in_data = d; in_mask = m; in_inv = inv;
      cycle();
      in_valid = 1'b0;
      cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] exp31;
      int          k;
      build_tables();

      // Power-up reset
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_acc_cnt", 64'(acc_cnt), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Known-answer vectors, two cycles from accept to out_valid
      out_ready = 1'b1;
      send_one(32'h0001_53FF, 4'hF, 1'b0);
      chk("kat_fwd_valid", 64'(out_valid), 64'd1);
      chk("kat_fwd_data", 64'(out_data), 64'h637C_ED16);
      cycle();
      exp31 = INV_EN ? 32'h0001_53FF : 32'hFB10_5547;
      send_one(32'h637C_ED16, 4'hF, 1'b1);
      chk("kat_inv_data", 64'(out_data), 64'(exp31));
      cycle();
      send_one(32'h0000_0000, 4'b0101, 1'b0);
      chk("kat_mask_data", 64'(out_data), 64'h0063_0063);
      cycle();

      // Full byte-value sweep, both directions, back to back
      for (int inv = 0; inv < 2; inv++) begin
         for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            in_mask  = 4'hF;
            in_inv   = 1'(inv);
            cycle();
         end
      end
      in_valid = 1'b0;
      repeat (3) cycle();

      // Ten-word stream with out_ready pattern 1,0,0
      do_reset();
      n_emit = 0;
      k = 0;
      while (k < 200 && (cnt_model < 10 || q.size() > 0)) begin
         out_ready = (k % 3 == 0);
         in_valid  = (cnt_model < 10);
         in_data   = $urandom;
         in_mask   = 4'($urandom_range(0, 15));
         in_inv    = 1'($urandom_range(0, 1));
         cycle();
         k++;
      end
      in_valid = 1'b0;
      chk("stream_drained", 64'(q.size()), 64'd0);
      chk("stream_emit", 64'(n_emit), 64'd10);
      chk("stream_acc_cnt", 64'(acc_cnt), 64'd10);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = $urandom;
         in_mask   = 4'($urandom_range(0, 15));
         in_inv    = 1'($urandom_range(0, 1));
         cycle();
      end
      in_valid = 1'b0;

      // Fill the pipe, reset for one cycle, make sure nothing stale escapes
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mask   = 4'hF;
      in_data   = 32'hA5A5_A5A5;
      cycle();
      in_data   = 32'h5A5A_5A5A;
      cycle();
      in_valid  = 1'b0;
      chk("fill_out_valid", 64'(out_valid), 64'd1);
      chk("fill_in_ready", 64'(in_ready), 64'd0);
      do_reset();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_acc_cnt", 64'(acc_cnt), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (5) cycle();

      // Narrow counter saturates at 15
      c4_in_valid = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         chk("c4_in_ready", 64'(c4_in_ready), 64'd1);
         @(posedge clk);
         #1;
         chk("c4_acc_cnt", 64'(c4_acc_cnt), 64'((i < 15) ? i : 15));
      end
      c4_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("c4_acc_hold", 64'(c4_acc_cnt), 64'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
